// File: rtl/pe_chain_scheduler.sv
// Sequencer for a linear chain of processing elements.
// Each layer runs in two phases. First, compute is launched in every PE and the
// completion flags are collected. Then the accumulator-forward path is granted
// one hop at a time (PE k -> PE k+1). This repeats for the programmed number of
// layers, and a one-cycle completion pulse is raised at the end.
module pe_chain_scheduler #(
  parameter int NUM_PE  = 4,
  parameter int LAYER_W = 4
) (
  input  logic               clk,
  input  logic               rst,            // asynchronous, active low
  input  logic               start,
  input  logic               abort,
  input  logic [LAYER_W-1:0] num_layers,
  input  logic [NUM_PE-1:0]  pe_done,
  input  logic [NUM_PE-1:0]  pe_recv_done,
  output logic [NUM_PE-1:0]  compute_start,
  output logic [NUM_PE-1:0]  fwd_grant,
  output logic               busy,
  output logic [LAYER_W-1:0] layer_idx,
  output logic               all_done
);

  // Hop index k ranges over 0..NUM_PE-2. The last PE never forwards.
  localparam int             K_W    = (NUM_PE > 2) ? $clog2(NUM_PE - 1) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(NUM_PE - 2);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_COMPUTE   = 3'd1;
  localparam logic [2:0] ST_FORWARD   = 3'd2;
  localparam logic [2:0] ST_LAYER_END = 3'd3;
  localparam logic [2:0] ST_FINISH    = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [K_W-1:0]     k_q, k_d;
  logic [NUM_PE-1:0]  collect_q, collect_d;
  logic [LAYER_W-1:0] layers_q, layers_d;
  logic [LAYER_W-1:0] layer_q, layer_d;
  logic               cstart_q, cstart_d;

  logic               collect_full;
  logic [NUM_PE-2:0]  hop_hit;
  logic               recv_hit;
  logic [NUM_PE-1:0]  grant_dec;

  // Bit 0 of the receive flags has no upstream sender, so it is never consulted.
  logic               unused_recv0;
  assign unused_recv0 = pe_recv_done[0];

  // The collect vector is registered. As a result, completion is seen one cycle
  // after the last flag arrives, which makes the second COMPUTE cycle the
  // earliest possible exit.
  assign collect_full = &collect_q;

  // Only the receiver of the currently granted hop (PE k+1) may advance the hop.
  // Pulses from all other PEs are discarded.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PE - 1; gi++) begin : g_hop
      assign hop_hit[gi] = (k_q == K_W'(gi)) & pe_recv_done[gi + 1];
    end
  endgenerate
  assign recv_hit = |hop_hit;

  // The grant is decoded from registered state only, so there is no
  // combinational path from an input to this output. The top bit stays 0
  // because the last PE has no downstream neighbour.
  generate
    for (gi = 0; gi < NUM_PE - 1; gi++) begin : g_grant
      assign grant_dec[gi] = (state_q == ST_FORWARD) && (k_q == K_W'(gi));
    end
  endgenerate
  assign grant_dec[NUM_PE-1] = 1'b0;

  // Next-state logic. An abort in any busy state overrides every other event.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    collect_d = collect_q;
    layers_d  = layers_q;
    layer_d   = layer_q;
    if ((state_q != ST_IDLE) && abort) begin
      state_d   = ST_IDLE;
      k_d       = '0;
      collect_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            // A zero layer count is promoted to one, so the layer index can never wrap.
            layers_d  = (num_layers == '0) ? LAYER_W'(1) : num_layers;
            layer_d   = '0;
            collect_d = '0;
            k_d       = '0;
            state_d   = ST_COMPUTE;
          end
        end
        ST_COMPUTE: begin
          collect_d = collect_q | pe_done;
          if (collect_full) begin
            state_d = ST_FORWARD;
            k_d     = '0;
          end
        end
        ST_FORWARD: begin
          if (recv_hit) begin
            if (k_q == K_LAST) begin
              state_d = ST_LAYER_END;
            end else begin
              k_d = k_q + K_W'(1);
            end
          end
        end
        ST_LAYER_END: begin
          if (layer_q == (layers_q - LAYER_W'(1))) begin
            state_d = ST_FINISH;
          end else begin
            layer_d   = layer_q + LAYER_W'(1);
            collect_d = '0;
            k_d       = '0;
            state_d   = ST_COMPUTE;
          end
        end
        ST_FINISH: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d   = ST_IDLE;
          k_d       = '0;
          collect_d = '0;
        end
      endcase
    end
  end

  // compute_start fires on every entry into COMPUTE, whether from IDLE or from
  // LAYER_END, and on no other cycle.
  assign cstart_d = (state_d == ST_COMPUTE) && (state_q != ST_COMPUTE);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      collect_q <= '0;
      layers_q  <= '0;
      layer_q   <= '0;
      cstart_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      collect_q <= collect_d;
      layers_q  <= layers_d;
      layer_q   <= layer_d;
      cstart_q  <= cstart_d;
    end
  end

  assign compute_start = {NUM_PE{cstart_q}};
  assign fwd_grant     = grant_dec;
  assign busy          = (state_q != ST_IDLE);
  assign layer_idx     = layer_q;
  assign all_done      = (state_q == ST_FINISH);

endmodule

// File: tb/tb_pe_chain_scheduler.sv
// Directed bench for pe_chain_scheduler.
// A phase-level reference model is stepped on every clock edge. All DUT
// outputs are compared against the model one time unit after each edge. A few
// literal latency and count checks pin the model to hand-derived values.
module tb_pe_chain_scheduler;
  localparam int NUM_PE  = 4;
  localparam int LAYER_W = 4;
  localparam logic [NUM_PE-1:0] ALL_ONES = '1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [LAYER_W-1:0] num_layers = '0;
  logic [NUM_PE-1:0]  pe_done = '0;
  logic [NUM_PE-1:0]  pe_recv_done = '0;
  logic [NUM_PE-1:0]  compute_start;
  logic [NUM_PE-1:0]  fwd_grant;
  logic               busy;
  logic [LAYER_W-1:0] layer_idx;
  logic               all_done;

  pe_chain_scheduler #(.NUM_PE(NUM_PE), .LAYER_W(LAYER_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .num_layers   (num_layers),
    .pe_done      (pe_done),
    .pe_recv_done (pe_recv_done),
    .compute_start(compute_start),
    .fwd_grant    (fwd_grant),
    .busy         (busy),
    .layer_idx    (layer_idx),
    .all_done     (all_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int edge_cnt = 0;
  int n_cs_seen = 0;
  int n_done_seen = 0;
  int done_edge = -1;
  int fwd_edge = -1;
  int s_edge = 0;
  int base_cs = 0;
  int base_done = 0;
  int grant_hist[$];
  logic [NUM_PE-1:0] last_grant = '0;

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_COMPUTE, M_FORWARD, M_LEND, M_FIN} mphase_t;
  mphase_t           m_phase;
  int                m_age;     // 1 on the first cycle of a phase visit
  logic [NUM_PE-1:0] m_seen;    // completion flags gathered before the current cycle
  int                m_hop;
  int                m_layer;
  int                m_total;

  task automatic model_reset();
    m_phase = M_IDLE; m_age = 1; m_seen = '0;
    m_hop = 0; m_layer = 0; m_total = 0;
  endtask

  task automatic model_step();
    mphase_t nxt;
    bit      entered;
    nxt = m_phase;
    entered = 1'b0;
    if (!rst) begin
      model_reset();
      return;
    end
    if (m_phase != M_IDLE && abort) begin
      nxt = M_IDLE; m_seen = '0; m_hop = 0;
    end else begin
      case (m_phase)
        M_IDLE: if (start && !abort) begin
          m_total = (num_layers == 0) ? 1 : int'(num_layers);
          m_layer = 0; m_seen = '0; m_hop = 0; nxt = M_COMPUTE;
        end
        M_COMPUTE: begin
          if (m_seen == ALL_ONES) begin nxt = M_FORWARD; m_hop = 0; end
          m_seen = m_seen | pe_done;
        end
        M_FORWARD: if (pe_recv_done[m_hop+1]) begin
          if (m_hop == NUM_PE - 2) nxt = M_LEND;
          else m_hop = m_hop + 1;
        end
        M_LEND: begin
          if (m_layer == m_total - 1) nxt = M_FIN;
          else begin
            m_layer = m_layer + 1; m_seen = '0; m_hop = 0;
            nxt = M_COMPUTE; entered = 1'b1;
          end
        end
        default: nxt = M_IDLE;
      endcase
    end
    if (nxt != m_phase || entered) m_age = 1;
    else m_age = m_age + 1;
    m_phase = nxt;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d, t=%0t)", name, act, exp, edge_cnt, $time);
    end
  endtask

  task automatic compare_all();
    logic [NUM_PE-1:0] exp_cs;
    logic [NUM_PE-1:0] exp_gr;
    exp_cs = (m_phase == M_COMPUTE && m_age == 1) ? ALL_ONES : '0;
    exp_gr = (m_phase == M_FORWARD) ? NUM_PE'(1 << m_hop) : '0;
    chk("compute_start", 32'(compute_start), 32'(exp_cs));
    chk("fwd_grant", 32'(fwd_grant), 32'(exp_gr));
    chk("busy", 32'(busy), 32'(m_phase != M_IDLE));
    chk("layer_idx", 32'(layer_idx), 32'(m_layer));
    chk("all_done", 32'(all_done), 32'(m_phase == M_FIN));
  endtask

  // One clock: step the model on the edge, then check and log observations 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    edge_cnt++;
    #1;
    compare_all();
    if (compute_start == ALL_ONES) n_cs_seen++;
    if (all_done === 1'b1) begin n_done_seen++; done_edge = edge_cnt; end
    if (fwd_grant != '0 && fwd_grant != last_grant) grant_hist.push_back(int'(fwd_grant));
    last_grant = fwd_grant;
    $display("edge %0d: cs=%b grant=%b busy=%b layer=%0d done=%b", edge_cnt, compute_start,
             fwd_grant, busy, layer_idx, all_done);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic do_start(input logic [LAYER_W-1:0] nl);
    num_layers = nl; start = 1'b1;
    cycle();
    start = 1'b0;
    num_layers = 4'hF;  // changes while busy must be ignored
  endtask

  task automatic wait_forward();
    int guard = 0;
    while (fwd_grant == '0 && guard < 20) begin cycle(); guard++; end
    chk("reach_forward", 32'(fwd_grant != '0), 32'd1);
    fwd_edge = edge_cnt;
  endtask

  // Entered on the first COMPUTE cycle; all flags are pulsed in cycle done_at.
  task automatic run_compute(input int done_at);
    for (int i = 1; i < done_at; i++) cycle();
    pe_done = ALL_ONES;
    cycle();
    pe_done = '0;
    wait_forward();
  endtask

  // Entered on the first grant cycle; each receive pulse comes delay cycles after its grant.
  task automatic run_forward(input int delay);
    for (int h = 0; h < NUM_PE - 1; h++) begin
      repeat (delay) cycle();
      pe_recv_done = NUM_PE'(1 << (h + 1));
      cycle();
      pe_recv_done = '0;
    end
  endtask

  task automatic run_layers(input int n, input int done_at, input int delay);
    for (int l = 0; l < n; l++) begin
      run_compute(done_at);
      run_forward(delay);
      cycle();  // LAYER_END -> COMPUTE or FINISH
    end
  endtask

  task automatic mark();
    base_cs = n_cs_seen; base_done = n_done_seen; grant_hist.delete();
  endtask

  initial begin
    model_reset();
    #1 rst = 1'b0;
    repeat (3) cycle();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_cs", 32'(compute_start), 32'd0);
    rst = 1'b1;
    repeat (2) cycle();

    // Single layer: flags in the 3rd COMPUTE cycle, receives 2 cycles after each grant.
    mark();
    do_start(4'd1); s_edge = edge_cnt;
    run_compute(3);
    chk("t1_fwd_latency", 32'(fwd_edge - s_edge), 32'd4);
    run_forward(2);
    cycle();
    chk("t1_done_latency", 32'(done_edge - s_edge), 32'd14);
    cycle();
    chk("t1_cs_pulses", 32'(n_cs_seen - base_cs), 32'd1);
    chk("t1_done_pulses", 32'(n_done_seen - base_done), 32'd1);
    chk("t1_grant_steps", 32'(grant_hist.size()), 32'd3);
    if (grant_hist.size() == 3) begin
      chk("t1_grant0", 32'(grant_hist[0]), 32'd1);
      chk("t1_grant1", 32'(grant_hist[1]), 32'd2);
      chk("t1_grant2", 32'(grant_hist[2]), 32'd4);
    end

    // Three layers.
    mark();
    do_start(4'd3);
    run_layers(3, 2, 1);
    cycle();
    chk("t2_cs_pulses", 32'(n_cs_seen - base_cs), 32'd3);
    chk("t2_done_pulses", 32'(n_done_seen - base_done), 32'd1);
    chk("t2_final_layer", 32'(layer_idx), 32'd2);

    // Zero layers are treated as one.
    mark();
    do_start(4'd0);
    run_layers(1, 1, 0);
    cycle();
    chk("t3_cs_pulses", 32'(n_cs_seen - base_cs), 32'd1);
    chk("t3_done_pulses", 32'(n_done_seen - base_done), 32'd1);
    chk("t3_final_layer", 32'(layer_idx), 32'd0);

    // Staggered completion pulses, and a spurious receive from the wrong PE.
    mark();
    do_start(4'd1); s_edge = edge_cnt;
    pe_done = 4'b0001; cycle();
    pe_done = 4'b0010; cycle();
    pe_done = 4'b0100; cycle();
    pe_done = 4'b0000; cycle();
    pe_done = 4'b1000; cycle();
    pe_done = 4'b0000;
    wait_forward();
    chk("t4_fwd_latency", 32'(fwd_edge - s_edge), 32'd6);
    pe_recv_done = 4'b1000; cycle(); pe_recv_done = '0;
    chk("t4_spurious_hold", 32'(fwd_grant), 32'd1);
    run_forward(1);
    cycle(); cycle();
    chk("t4_done_pulses", 32'(n_done_seen - base_done), 32'd1);

    // Abort with grant 0010. A receive in the same cycle loses to the abort.
    mark();
    do_start(4'd2);
    run_compute(1);
    cycle();
    pe_recv_done = 4'b0010; cycle(); pe_recv_done = '0;
    chk("t5_pre_abort_grant", 32'(fwd_grant), 32'd2);
    abort = 1'b1; pe_recv_done = 4'b0100;
    cycle();
    abort = 1'b0; pe_recv_done = '0;
    chk("t5_abort_busy", 32'(busy), 32'd0);
    chk("t5_abort_grant", 32'(fwd_grant), 32'd0);
    repeat (3) cycle();
    chk("t5_no_done", 32'(n_done_seen - base_done), 32'd0);
    start = 1'b1; abort = 1'b1;  // abort in IDLE blocks start
    cycle();
    start = 1'b0; abort = 1'b0;
    chk("t5_idle_abort_blocks", 32'(busy), 32'd0);
    do_start(4'd1);
    chk("t5_restart_layer", 32'(layer_idx), 32'd0);
    chk("t5_restart_cs", 32'(compute_start), 32'(ALL_ONES));
    run_layers(1, 1, 1);
    cycle();
    chk("t5_restart_done", 32'(n_done_seen - base_done), 32'd1);

    // Start while busy is ignored. Then an asynchronous reset arrives mid-COMPUTE.
    mark();
    do_start(4'd2);
    start = 1'b1;
    cycle(); cycle();
    start = 1'b0;
    chk("t6_busy_start_ignored", 32'(n_cs_seen - base_cs), 32'd1);
    #2 rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("t6_async_busy", 32'(busy), 32'd0);
    cycle(); cycle();
    rst = 1'b1;
    cycle(); cycle();
    chk("t6_after_reset_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pe_chain_scheduler.md
Name: pe_chain_scheduler

Overview:
Top-level sequencer for a linear chain of NUM_PE processing elements. Each PE has a receive controller for partial-sum handoff. For every layer, the block launches compute in all PEs and collects their completion flags. It then grants the accumulator-forward path one hop at a time, PE k to PE k+1, repeats for the programmed layer count, and signals completion.

Parameters:
NUM_PE, 4, number of PEs in the chain (>=2)
LAYER_W, 4, width of layer count and layer index

Ports:
clk  input  1  global clock
rst  input  1  asynchronous active-low reset
start  input  1  run request; sampled only in IDLE
abort  input  1  synchronous abort; highest priority after reset
num_layers  input  LAYER_W  layers to run; sampled at accepted start; 0 treated as 1
pe_done  input  NUM_PE  per-PE compute-complete flag, level or pulse
pe_recv_done  input  NUM_PE  per-PE receive-complete pulse (bit 0 unused)
compute_start  output  NUM_PE  one-cycle broadcast start pulse, all bits equal
fwd_grant  output  NUM_PE  one-hot; bit k = PE k may drive acc path to PE k+1
busy  output  1  high in every state except IDLE
layer_idx  output  LAYER_W  current layer, 0-based
all_done  output  1  one-cycle pulse after the last layer completes

Behaviour:
- Reset (async, rst=0): state=IDLE; all outputs 0; internal registers cleared (layer count, hop index k, done-collect vector, latched num_layers).
- All outputs are registered or decoded from registered state only; no combinational input-to-output path.
- States: IDLE, COMPUTE, FORWARD, LAYER_END, FINISH.
- IDLE:
  - start=1 and abort=0 -> latch max(num_layers,1), layer_idx<=0, clear done-collect, go to COMPUTE.
  - start is ignored in all other states.
- COMPUTE:
  - compute_start=all-ones for exactly the first cycle in the state.
  - done-collect |= pe_done every cycle, including the first cycle (same-cycle done is accepted).
  - When done-collect is all ones, go to FORWARD with k=0. The exit is registered: the earliest exit is the second cycle in the state.
- FORWARD:
  - fwd_grant = one-hot(k).
  - pe_recv_done[k+1]=1 -> if k==NUM_PE-2, go to LAYER_END; else k<=k+1 and stay.
  - Grant changes in the cycle after the qualifying pulse. At least one cycle of grant precedes any hop advance.
  - pe_recv_done bits other than k+1 are ignored.
- LAYER_END (1 cycle):
  - layer_idx==latched-1 -> FINISH.
  - Otherwise layer_idx<=layer_idx+1, clear done-collect, k<=0, go to COMPUTE.
- FINISH (1 cycle): all_done=1, then IDLE. layer_idx holds its final value until the next accepted start.
- abort=1 in any non-IDLE state: next state IDLE. compute_start and fwd_grant go to 0 next cycle. No all_done pulse. Collect vector cleared.
- abort in IDLE has no effect; start is blocked that cycle.
- abort beats start, recv_done and done-collect completion in the same cycle.
- layer_idx counts 0..latched-1. Wrap is impossible because the latched count is at most 2^LAYER_W-1.
- A change to num_layers while busy has no effect.

Test Plan:
- NUM_PE=4, num_layers=1, start; all pe_done in the 3rd COMPUTE cycle; recv_done[1],[2],[3] 2 cycles after each grant -> compute_start=4'b1111 for 1 cycle; fwd_grant 0001->0010->0100; one all_done pulse; busy falls with it.
- num_layers=3 -> compute_start pulses 3 times; layer_idx 0,1,2; all_done exactly once; layer_idx=2 after done.
- num_layers=0 -> behaves as 1 layer, single all_done.
- pe_done bits arrive as staggered single-cycle pulses (bit0 cycle 1, bit3 cycle 5) -> FORWARD entered only after bit3. Spurious recv_done[3] while grant=0001 -> no advance.
- abort asserted during FORWARD with grant=0010 -> next cycle IDLE, fwd_grant=0, busy=0, no all_done; a following start restarts at layer 0.
- rst pulled low mid-COMPUTE, asynchronously between clock edges -> outputs 0 immediately. start asserted while busy -> ignored, no extra compute_start.
